// File: rtl/err_comp_pkg.sv
// Shared definitions for the error-compensation datapath: default widths and
// the window accumulator state encoding.
package err_comp_pkg;

   localparam int unsigned DEF_ERR_W  = 8;
   localparam int unsigned DEF_SUM_W  = 16;
   localparam int unsigned DEF_WINDOW = 64;
   localparam int unsigned DEF_CNT_W  = 7;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } acc_state_e;

endpackage

// File: rtl/error_sum_accumulator_sat_adder.sv
// Unsigned saturating add of a narrow term onto a wider accumulator.
// The result clamps at all-ones; the overflow flag reports the clamp.
module error_sum_accumulator_sat_adder #(
   parameter int unsigned A_W = 16,
   parameter int unsigned B_W = 8
) (
   input  logic [A_W-1:0] a,
   input  logic [B_W-1:0] b,
   output logic [A_W-1:0] sum_c,
   output logic           ovf_c
);

   logic [A_W:0] raw;

   always_comb begin
      raw   = {1'b0, a} + (A_W+1)'(b);
      ovf_c = raw[A_W];
      sum_c = ovf_c ? '1 : raw[A_W-1:0];
   end

endmodule

// File: rtl/error_sum_accumulator.sv
// Collects per-MAC error-compensation terms over one dot-product window and
// hands the saturated sum to a one-entry valid/ready output register.
module error_sum_accumulator
   import err_comp_pkg::*;
#(
   parameter int unsigned ERR_W  = DEF_ERR_W,
   parameter int unsigned SUM_W  = DEF_SUM_W,
   parameter int unsigned WINDOW = DEF_WINDOW,
   parameter int unsigned CNT_W  = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             err_valid,
   output logic             err_ready,
   input  logic [ERR_W-1:0] err_term,
   input  logic             err_last,
   output logic [SUM_W-1:0] err_sum,
   output logic             err_sum_valid,
   input  logic             err_sum_ready,
   output logic             err_sum_sat,
   output logic [CNT_W-1:0] beat_cnt
);

   acc_state_e       state, state_d;
   logic [SUM_W-1:0] acc, acc_d;
   logic             sat, sat_d;
   logic [CNT_W-1:0] cnt_d;
   logic [SUM_W-1:0] sum_d;
   logic             sum_valid_d;
   logic             sum_sat_d;
   logic             ready_d;

   logic [SUM_W-1:0] add_sum_c;
   logic             add_ovf_c;
   logic             accepted_c;
   logic             closing_c;
   logic             out_free_c;

   error_sum_accumulator_sat_adder #(
      .A_W (SUM_W),
      .B_W (ERR_W)
   ) sat_adder_u (
      .a     (acc),
      .b     (err_term),
      .sum_c (add_sum_c),
      .ovf_c (add_ovf_c)
   );

   always_comb begin
      accepted_c = err_valid & err_ready;
      closing_c  = accepted_c & (err_last | (beat_cnt == CNT_W'(WINDOW - 1)));
      out_free_c = ~err_sum_valid | err_sum_ready;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ACCUM;
      else        state <= state_d;
   end

   // Next-state, accumulator, counter and output-register updates
   always_comb begin
      state_d     = state;
      acc_d       = acc;
      sat_d       = sat;
      cnt_d       = beat_cnt;
      sum_d       = err_sum;
      sum_sat_d   = err_sum_sat;
      sum_valid_d = err_sum_valid & ~err_sum_ready;

      if (clr) begin
         state_d = ACCUM;
         acc_d   = '0;
         sat_d   = 1'b0;
         cnt_d   = '0;
      end else begin
         unique case (state)
            ACCUM: begin
               if (closing_c && out_free_c) begin
                  sum_d       = add_sum_c;
                  sum_sat_d   = sat | add_ovf_c;
                  sum_valid_d = 1'b1;
                  acc_d       = '0;
                  sat_d       = 1'b0;
                  cnt_d       = '0;
               end else if (accepted_c) begin
                  acc_d = add_sum_c;
                  sat_d = sat | add_ovf_c;
                  cnt_d = beat_cnt + CNT_W'(1);
                  if (closing_c) state_d = HOLD;
               end
            end
            HOLD: begin
               // Closed window waits in acc until the output register drains
               if (err_sum_ready) begin
                  sum_d       = acc;
                  sum_sat_d   = sat;
                  sum_valid_d = 1'b1;
                  acc_d       = '0;
                  sat_d       = 1'b0;
                  cnt_d       = '0;
                  state_d     = ACCUM;
               end
            end
            default: state_d = ACCUM;
         endcase
      end

      ready_d = (state_d == ACCUM);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc           <= '0;
         sat           <= 1'b0;
         beat_cnt      <= '0;
         err_sum       <= '0;
         err_sum_sat   <= 1'b0;
         err_sum_valid <= 1'b0;
         err_ready     <= 1'b0;
      end else begin
         acc           <= acc_d;
         sat           <= sat_d;
         beat_cnt      <= cnt_d;
         err_sum       <= sum_d;
         err_sum_sat   <= sum_sat_d;
         err_sum_valid <= sum_valid_d;
         err_ready     <= ready_d;
      end
   end

endmodule

// File: tb/tb_error_sum_accumulator.sv
// Scoreboard bench for error_sum_accumulator: a 64-beat window instance and a
// 512-beat window instance for the saturation cases.
module tb_error_sum_accumulator;

   typedef struct packed {
      logic        sat;
      logic [15:0] s;
   } exp_t;

   logic clk;
   logic rst_n;

   logic        clr, err_valid, err_last, err_sum_ready;
   logic [7:0]  err_term;
   logic        err_ready, err_sum_valid, err_sum_sat;
   logic [15:0] err_sum;
   logic [6:0]  beat_cnt;

   logic        w_clr, w_valid, w_last, w_sum_ready;
   logic [7:0]  w_term;
   logic        w_ready, w_sum_valid, w_sum_sat;
   logic [15:0] w_sum;
   logic [9:0]  w_cnt;

   int checks   = 0;
   int failures = 0;
   exp_t q[$];
   exp_t qw[$];

   error_sum_accumulator #(.ERR_W(8), .SUM_W(16), .WINDOW(64), .CNT_W(7)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .err_valid(err_valid), .err_ready(err_ready),
      .err_term(err_term), .err_last(err_last), .err_sum(err_sum),
      .err_sum_valid(err_sum_valid), .err_sum_ready(err_sum_ready),
      .err_sum_sat(err_sum_sat), .beat_cnt(beat_cnt)
   );

   error_sum_accumulator #(.ERR_W(8), .SUM_W(16), .WINDOW(512), .CNT_W(10)) dut_w (
      .clk(clk), .rst_n(rst_n), .clr(w_clr), .err_valid(w_valid), .err_ready(w_ready),
      .err_term(w_term), .err_last(w_last), .err_sum(w_sum),
      .err_sum_valid(w_sum_valid), .err_sum_ready(w_sum_ready),
      .err_sum_sat(w_sum_sat), .beat_cnt(w_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [15:0] s, input logic sat);
      exp_t e;
      e.s = s; e.sat = sat;
      q.push_back(e);
   endtask

   task automatic push_w(input logic [15:0] s, input logic sat);
      exp_t e;
      e.s = s; e.sat = sat;
      qw.push_back(e);
   endtask

   // Pops the scoreboard on every output handshake of either instance
   task automatic monitor();
      exp_t e;
      logic pv = 1'b0, pr = 1'b0;
      logic [15:0] ps = '0;
      logic ps_sat = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pv = 1'b0;
         end else begin
            if (pv && !pr) begin
               chk("hold_stable_sum", err_sum, ps);
               chk("hold_stable_sat", err_sum_sat, ps_sat);
            end
            if (err_sum_valid && err_sum_ready) begin
               if (q.size() == 0) chk("unexpected_out", err_sum, 32'hFFFF_FFFF);
               else begin
                  e = q.pop_front();
                  chk("err_sum", err_sum, e.s);
                  chk("err_sum_sat", err_sum_sat, e.sat);
               end
            end
            if (w_sum_valid && w_sum_ready) begin
               if (qw.size() == 0) chk("w_unexpected_out", w_sum, 32'hFFFF_FFFF);
               else begin
                  e = qw.pop_front();
                  chk("w_err_sum", w_sum, e.s);
                  chk("w_err_sum_sat", w_sum_sat, e.sat);
               end
            end
            pv = err_sum_valid; pr = err_sum_ready; ps = err_sum; ps_sat = err_sum_sat;
         end
      end
   endtask

   task automatic beat(input logic [7:0] t, input logic last);
      err_valid = 1'b1; err_term = t; err_last = last;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (err_ready) begin
            @(posedge clk); #1;
            err_valid = 1'b0; err_last = 1'b0;
            return;
         end
      end
      chk("beat_timeout", 0, 1);
      err_valid = 1'b0; err_last = 1'b0;
   endtask

   task automatic beat_w(input logic [7:0] t, input logic last);
      w_valid = 1'b1; w_term = t; w_last = last;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (w_ready) begin
            @(posedge clk); #1;
            w_valid = 1'b0; w_last = 1'b0;
            return;
         end
      end
      chk("w_beat_timeout", 0, 1);
      w_valid = 1'b0; w_last = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 50 && (q.size() != 0 || qw.size() != 0); n++) @(posedge clk);
      #1;
      chk("drain_empty", 32'(q.size() + qw.size()), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; clr = 1'b0; err_valid = 1'b0; err_last = 1'b0; err_term = '0;
      err_sum_ready = 1'b1;
      w_clr = 1'b0; w_valid = 1'b0; w_last = 1'b0; w_term = '0; w_sum_ready = 1'b1;
      fork monitor(); join_none

      // Reset state
      #12;
      chk("rst_err_sum", err_sum, 0);
      chk("rst_valid", err_sum_valid, 0);
      chk("rst_sat", err_sum_sat, 0);
      chk("rst_beat_cnt", beat_cnt, 0);
      chk("rst_ready", err_ready, 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk); #1;
      chk("ready_after_rst", err_ready, 1);

      // 1: four beats of 3
      push(16'd12, 1'b0);
      beat(8'd3, 1'b0); beat(8'd3, 1'b0); beat(8'd3, 1'b0);
      chk("t1_cnt3", beat_cnt, 3);
      beat(8'd3, 1'b1);
      chk("t1_cnt0", beat_cnt, 0);
      chk("t1_valid", err_sum_valid, 1);
      @(posedge clk); #1;
      chk("t1_valid_drop", err_sum_valid, 0);

      // 2: forced close, then new window, then err_last on beat 64, zero terms
      push(16'd64, 1'b0);
      for (int i = 0; i < 64; i++) beat(8'd1, 1'b0);
      chk("t2_cnt_forced", beat_cnt, 0);
      beat(8'd1, 1'b0);
      chk("t2_cnt_new", beat_cnt, 1);
      push(16'd2, 1'b0);
      beat(8'd1, 1'b1);
      push(16'd64, 1'b0);
      for (int i = 0; i < 64; i++) beat(8'd1, i == 63);
      chk("t2_last_on_window", beat_cnt, 0);
      beat(8'd0, 1'b0); beat(8'd0, 1'b0);
      chk("t2_zero_cnt", beat_cnt, 2);
      push(16'd5, 1'b0);
      beat(8'd5, 1'b1);
      drain();

      // 3: back-to-back saturating-free windows with downstream stalled
      err_sum_ready = 1'b0;
      push(16'd2040, 1'b0); push(16'd2040, 1'b0);
      for (int i = 0; i < 8; i++) beat(8'd255, i == 7);
      for (int i = 0; i < 8; i++) beat(8'd255, i == 7);
      chk("t3_hold_ready", err_ready, 0);
      chk("t3_first_sum", err_sum, 2040);
      err_valid = 1'b1; err_term = 8'd4; err_last = 1'b1;
      repeat (3) @(posedge clk); #1;
      chk("t3_still_hold", err_ready, 0);
      chk("t3_valid_held", err_sum_valid, 1);
      err_sum_ready = 1'b1;
      push(16'd4, 1'b0);
      beat(8'd4, 1'b1);
      drain();

      // 5: clr mid-window with a pending output
      err_sum_ready = 1'b0;
      push(16'd9, 1'b0);
      beat(8'd4, 1'b0); beat(8'd5, 1'b1);
      for (int i = 0; i < 5; i++) beat(8'd7, 1'b0);
      chk("t5_cnt5", beat_cnt, 5);
      clr = 1'b1; err_valid = 1'b1; err_term = 8'd7;
      @(posedge clk); #1;
      clr = 1'b0; err_valid = 1'b0;
      chk("t5_clr_cnt", beat_cnt, 0);
      chk("t5_pending_sum", err_sum, 9);
      chk("t5_pending_valid", err_sum_valid, 1);
      push(16'd2, 1'b0);
      beat(8'd1, 1'b0); beat(8'd1, 1'b1);
      err_sum_ready = 1'b1;
      drain();

      // 4: saturation on the wide-window instance
      push_w(16'd65535, 1'b0);
      for (int i = 0; i < 257; i++) beat_w(8'd255, i == 256);
      push_w(16'd65535, 1'b1);
      for (int i = 0; i < 300; i++) beat_w(8'd255, i == 299);
      push_w(16'd2, 1'b0);
      beat_w(8'd1, 1'b0); beat_w(8'd1, 1'b1);
      drain();

      // 6: async reset while in HOLD
      err_sum_ready = 1'b0;
      push(16'd3, 1'b0);
      beat(8'd3, 1'b1);
      beat(8'd1, 1'b0); beat(8'd1, 1'b1);
      chk("t6_hold", err_ready, 0);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("t6_sum0", err_sum, 0);
      chk("t6_valid0", err_sum_valid, 0);
      chk("t6_sat0", err_sum_sat, 0);
      chk("t6_cnt0", beat_cnt, 0);
      chk("t6_ready0", err_ready, 0);
      q.delete();
      repeat (2) @(posedge clk); #2;
      rst_n = 1'b1;
      err_sum_ready = 1'b1;
      repeat (5) @(posedge clk); #1;
      chk("t6_no_spurious", err_sum_valid, 0);
      push(16'd4, 1'b0);
      beat(8'd2, 1'b0); beat(8'd2, 1'b1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
